// File: rtl/sr_pkg.sv
// sr_pkg: shared FSM states and SR excitation codes ({s, r}) for the SR driver.
package sr_pkg;
   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FAULT} state_e;
   localparam logic [1:0] HOLD = 2'b00;
   localparam logic [1:0] SET  = 2'b10;
   localparam logic [1:0] RST  = 2'b01;
endpackage

// File: rtl/sr_excite.sv
// sr_excite: SR flip-flop excitation table, current state q to requested q_next.
module sr_excite
   import sr_pkg::*;
(
   input  logic q,
   input  logic q_next,
   output logic s,
   output logic r
);
   logic [1:0] code;
   always_comb code = (q_next && !q) ? SET : (!q_next && q) ? RST : HOLD;
   assign {s, r} = code;
endmodule

// File: rtl/sr_excite_driver.sv
// sr_excite_driver: drives an external SR flip-flop to a requested state,
// checks its readback one cycle later and tracks mismatches.
module sr_excite_driver
   import sr_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tgt_valid,
   input  logic             tgt_bit,
   output logic             tgt_ready,
   output logic             s_out,
   output logic             r_out,
   input  logic             q_fb,
   output logic             done,
   output logic             err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] err_cnt
);
   state_e state_q;
   logic   tgt_q, q_model_q, s_d, r_d;

   // excitation is computed from the incoming bit so s_out/r_out are registered into DRIVE
   sr_excite u_excite (
      .q     (q_model_q),
      .q_next(tgt_bit),
      .s     (s_d),
      .r     (r_d)
   );

   assign tgt_ready = state_q == IDLE;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q   <= IDLE;
         tgt_q     <= 1'b0;
         q_model_q <= 1'b0;
         s_out     <= 1'b0;
         r_out     <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_cnt   <= '0;
      end else begin
         s_out <= 1'b0;
         r_out <= 1'b0;
         done  <= 1'b0;
         case (state_q)
            IDLE:
               if (tgt_valid) begin
                  tgt_q   <= tgt_bit;
                  s_out   <= s_d;
                  r_out   <= r_d;
                  state_q <= DRIVE;
               end
            DRIVE: state_q <= CHECK;
            CHECK: begin
               q_model_q <= q_fb;
               if (q_fb == tgt_q) begin
                  done    <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  err     <= 1'b1;
                  err_cnt <= (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
                  state_q <= FAULT;
               end
            end
            FAULT:
               if (err_clr) begin
                  err     <= 1'b0;
                  state_q <= IDLE;
               end
            default: state_q <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_sr_excite_driver.sv
// tb_sr_excite_driver: random requests against a model SR flip-flop with injected
// readback faults; expected outcomes are queued and checked by a separate monitor.
module tb_sr_excite_driver;
   typedef struct {
      bit s, r, d, e;
      int cnt, cnt2, cyc;
   } exp_t;

   logic clk = 0, reset = 1, tgt_valid = 0, tgt_bit = 0, err_clr = 0;
   logic force_en = 0, force_val = 0, q_ff, q_fb;
   logic tgt_ready, s_out, r_out, done, err;
   logic tgt_ready2, s_out2, r_out2, done2, err2;
   logic [7:0] err_cnt;
   logic [1:0] err_cnt2;
   int tests = 0, fails = 0, cyc = 0;
   int m_cnt = 0, m_cnt2 = 0;
   bit m_q = 0, m_ff = 0, s_seen = 0, r_seen = 0, err_d = 0;
   exp_t sb[$];
   exp_t me;

   sr_excite_driver dut (
      .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
      .tgt_ready(tgt_ready), .s_out(s_out), .r_out(r_out), .q_fb(q_fb),
      .done(done), .err(err), .err_clr(err_clr), .err_cnt(err_cnt)
   );

   sr_excite_driver #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
      .tgt_ready(tgt_ready2), .s_out(s_out2), .r_out(r_out2), .q_fb(q_fb),
      .done(done2), .err(err2), .err_clr(err_clr), .err_cnt(err_cnt2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // the driven SR flip-flop; fault injection overrides what it reports
   always @(posedge clk or posedge reset)
      if (reset) q_ff <= 1'b0;
      else if (s_out) q_ff <= 1'b1;
      else if (r_out) q_ff <= 1'b0;
   assign q_fb = force_en ? force_val : q_ff;

   task automatic chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         s_seen = 0;
         r_seen = 0;
         err_d  = 0;
      end else begin
         chk("s_and_r", s_out & r_out, 0);
         chk("s_and_r2", s_out2 & r_out2, 0);
         s_seen |= s_out;
         r_seen |= r_out;
         if (done || (err && !err_d)) begin
            if (sb.size() == 0) chk("unexpected_completion", 1, 0);
            else begin
               me = sb.pop_front();
               chk("done", done, me.d);
               chk("done2", done2, me.d);
               chk("err", err, me.e);
               chk("err2", err2, me.e);
               chk("err_cnt", err_cnt, me.cnt);
               chk("err_cnt2", err_cnt2, me.cnt2);
               chk("s_pulse", s_seen, me.s);
               chk("r_pulse", r_seen, me.r);
               chk("latency", cyc, me.cyc);
            end
            s_seen = 0;
            r_seen = 0;
         end
         err_d = err;
      end
   end

   task automatic do_req(bit tb, bit fault, bit hold);
      int n = 0;
      exp_t e;
      bit fb, match;
      @(negedge clk);
      while (!tgt_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", tgt_ready, 1);
      if (!tgt_ready) begin
         tgt_valid = 0;
         return;
      end
      e.s   = tb && !m_q;
      e.r   = !tb && m_q;
      m_ff  = e.s ? 1'b1 : e.r ? 1'b0 : m_ff;
      fb    = fault ? !tb : m_ff;
      match = fb == tb;
      e.d   = match;
      e.e   = !match;
      if (!match) begin
         m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
         m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
      m_q    = fb;
      e.cnt  = m_cnt;
      e.cnt2 = m_cnt2;
      force_en  = fault;
      force_val = !tb;
      tgt_valid = 1;
      tgt_bit   = tb;
      err_clr   = 1'($urandom);
      @(posedge clk);
      #1;
      e.cyc = cyc + 2;
      sb.push_back(e);
      if (!hold || !match) tgt_valid = 0;
      repeat (2) begin
         @(negedge clk);
         tgt_bit = 1'($urandom);
         err_clr = 1'($urandom);
      end
      if (!match) begin
         @(negedge clk);
         err_clr = 0;
         chk("fault_ready", tgt_ready, 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         err_clr = 1;
         @(negedge clk);
         err_clr = 0;
         chk("clr_err", err, 0);
         chk("clr_ready", tgt_ready, 1);
         chk("cnt_kept", err_cnt, m_cnt);
         chk("cnt2_kept", err_cnt2, m_cnt2);
      end
   endtask

   task automatic reset_in_drive();
      @(negedge clk);
      force_en  = 0;
      err_clr   = 0;
      tgt_valid = 1;
      tgt_bit   = !m_q;
      @(posedge clk);
      #1 tgt_valid = 0;
      @(negedge clk);
      chk("abort_pulse", s_out | r_out, 1);
      #2 reset = 1;
      #1;
      chk("abort_s", s_out, 0);
      chk("abort_r", r_out, 0);
      @(negedge clk);
      #1 reset = 0;
      m_q = 0; m_ff = 0; m_cnt = 0; m_cnt2 = 0;
      @(negedge clk);
      chk("abort_ready", tgt_ready, 1);
      chk("abort_err", err, 0);
      chk("abort_cnt", err_cnt, 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ready", tgt_ready, 1);
      chk("rst_s", s_out, 0);
      chk("rst_r", r_out, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_cnt", err_cnt, 0);
      #1 reset = 0;
      @(negedge clk);
      chk("post_rst_ready", tgt_ready, 1);
      chk("post_rst_ready2", tgt_ready2, 1);
      do_req(1, 0, 0);
      do_req(0, 0, 0);
      do_req(1, 0, 0);
      do_req(1, 0, 0);
      do_req(1, 1, 0);
      for (int i = 0; i < 4; i++) do_req(1'($urandom), 1, 0);
      do_req(0, 0, 1);
      do_req(1, 0, 1);
      do_req(1, 0, 0);
      reset_in_drive();
      for (int i = 0; i < 40; i++)
         do_req(1'($urandom), $urandom_range(0, 3) == 0, i < 39 && $urandom_range(0, 2) == 0);
      tgt_valid = 0;
      repeat (5) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
